// File: rtl/fifo_256_credit_rd.sv
// Read-side stage of fifo_256: two-entry skid buffer, packet framing and registered credit return.
// Optional stall counter enabled by defining FIFO_256_CREDIT_RD_STALL_CNT_EN.
module fifo_256_credit_rd #(
    parameter int DW           = 16,
    parameter int PKT_WORDS    = 16,
    parameter int CREDIT_WORDS = 16,
    parameter int CW           = $clog2(CREDIT_WORDS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] fifo_data_i,
    input  logic          fifo_empty_i,
    output logic          fifo_rd_o,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          credit_flush_i,
    output logic          credit_o,
    output logic [CW-1:0] credit_num_o,
    output logic [15:0]   stall_cnt_o
);

    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int EW = DW + 1;

    logic [EW-1:0] ent0_reg, ent0_next;
    logic [EW-1:0] ent1_reg, ent1_next;
    logic [1:0]    occ_reg, occ_next;
    logic [PW-1:0] pkt_cnt_reg, pkt_cnt_next;
    logic [CW-1:0] credit_cnt_reg, credit_cnt_next;
    logic [CW-1:0] credit_num_reg, credit_num_next;
    logic          credit_reg, credit_next;
    logic [CW-1:0] nc;
    logic          push, pop, push_last;
    logic [EW-1:0] push_ent;

    // Read gating depends only on buffer occupancy, never on out_ready.
    assign fifo_rd_o = reset_n & ~fifo_empty_i & (occ_reg != 2'd2);
    assign push      = fifo_rd_o;
    assign out_valid = (occ_reg != 2'd0);
    assign pop       = out_valid & out_ready;
    assign {out_last, out_data} = ent0_reg;

    assign push_last = (pkt_cnt_reg == PW'(PKT_WORDS - 1));
    assign push_ent  = {push_last, fifo_data_i};

    always_comb begin
        ent0_next    = ent0_reg;
        ent1_next    = ent1_reg;
        occ_next     = occ_reg;
        pkt_cnt_next = pkt_cnt_reg;
        case ({push, pop})
            2'b10: begin
                if (occ_reg == 2'd0) ent0_next = push_ent;
                else                 ent1_next = push_ent;
                occ_next = occ_reg + 2'd1;
            end
            2'b01: begin
                ent0_next = ent1_reg;
                occ_next  = occ_reg - 2'd1;
            end
            // Push implies occ<2 and pop implies occ>0, so this is occ==1: replace head.
            2'b11:   ent0_next = push_ent;
            default: ;
        endcase
        if (push) pkt_cnt_next = push_last ? '0 : pkt_cnt_reg + 1'b1;
    end

    always_comb begin
        nc              = credit_cnt_reg + CW'(pop);
        credit_next     = 1'b0;
        credit_num_next = '0;
        credit_cnt_next = nc;
        if ((nc == CW'(CREDIT_WORDS)) || (credit_flush_i && (nc != '0))) begin
            credit_next     = 1'b1;
            credit_num_next = nc;
            credit_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_reg       <= '0;
            ent1_reg       <= '0;
            occ_reg        <= '0;
            pkt_cnt_reg    <= '0;
            credit_cnt_reg <= '0;
            credit_num_reg <= '0;
            credit_reg     <= 1'b0;
        end else begin
            ent0_reg       <= ent0_next;
            ent1_reg       <= ent1_next;
            occ_reg        <= occ_next;
            pkt_cnt_reg    <= pkt_cnt_next;
            credit_cnt_reg <= credit_cnt_next;
            credit_num_reg <= credit_num_next;
            credit_reg     <= credit_next;
        end
    end

    assign credit_o     = credit_reg;
    assign credit_num_o = credit_num_reg;

`ifdef FIFO_256_CREDIT_RD_STALL_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of cycles where a word is offered but not taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cnt_reg <= '0;
        else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF))
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end

    assign stall_cnt_o = stall_cnt_reg;
`else
    assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_fifo_256_credit_rd.sv
// Randomised bench for fifo_256_credit_rd against a queue-based reference model.
module tb_fifo_256_credit_rd;
    localparam int DW           = 16;
    localparam int PKT_WORDS    = 16;
    localparam int CREDIT_WORDS = 16;
    localparam int CW           = $clog2(CREDIT_WORDS + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_rd_o;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          credit_flush_i;
    logic          credit_o;
    logic [CW-1:0] credit_num_o;
    logic [15:0]   stall_cnt_o;

    always #5 clk = ~clk;

    fifo_256_credit_rd #(
        .DW(DW), .PKT_WORDS(PKT_WORDS), .CREDIT_WORDS(CREDIT_WORDS)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fifo_data_i(fifo_data_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .credit_flush_i(credit_flush_i), .credit_o(credit_o), .credit_num_o(credit_num_o),
        .stall_cnt_o(stall_cnt_o)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [16:0] mdl_buf[$];
    int          mdl_pkt, mdl_ccnt, mdl_credit, mdl_num, mdl_stall;
    int          popped, credit_sum;
    logic [15:0] src_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        mdl_buf.delete();
        mdl_pkt = 0; mdl_ccnt = 0; mdl_credit = 0; mdl_num = 0; mdl_stall = 0;
        popped = 0; credit_sum = 0;
    endtask

    // One clock cycle: check outputs, drive inputs, check read, advance model.
    task automatic step(input bit e, input bit r, input bit f);
        bit mv, exp_rd, pop;
        int nc;
        mv = (mdl_buf.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(mv));
        if (mv) begin
            chk("out_data", 32'(out_data), 32'(mdl_buf[0][15:0]));
            chk("out_last", 32'(out_last), 32'(mdl_buf[0][16]));
        end
        chk("credit_o", 32'(credit_o), 32'(mdl_credit));
        chk("credit_num", 32'(credit_num_o), 32'(mdl_num));
`ifdef FIFO_256_CREDIT_RD_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt_o), 32'(mdl_stall));
`else
        chk("stall_cnt", 32'(stall_cnt_o), 32'h0);
`endif
        credit_sum += int'(credit_num_o);

        fifo_empty_i   = e;
        fifo_data_i    = e ? 16'($urandom) : src_word;
        out_ready      = r;
        credit_flush_i = f;
        #1;
        exp_rd = !e && (mdl_buf.size() < 2);
        chk("fifo_rd", 32'(fifo_rd_o), 32'(exp_rd));
        pop = mv && r;

        @(negedge clk);
        if (pop) begin
            void'(mdl_buf.pop_front());
            popped++;
        end
        if (exp_rd) begin
            mdl_buf.push_back({(mdl_pkt == PKT_WORDS - 1), src_word});
            mdl_pkt  = (mdl_pkt + 1) % PKT_WORDS;
            src_word = src_word + 16'd1;
        end
        nc = mdl_ccnt + int'(pop);
        if (nc == CREDIT_WORDS || (f && nc != 0)) begin
            mdl_credit = 1; mdl_num = nc; mdl_ccnt = 0;
        end else begin
            mdl_credit = 0; mdl_num = 0; mdl_ccnt = nc;
        end
        if (mv && !r && mdl_stall < 65535) mdl_stall++;
        $display("cyc empty=%0b ready=%0b flush=%0b rd=%0b occ=%0d credit=%0d/%0d",
                 e, r, f, exp_rd, mdl_buf.size(), mdl_credit, mdl_num);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rd", 32'(fifo_rd_o), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_credit", 32'(credit_o), 32'h0);
        chk("rst_num", 32'(credit_num_o), 32'h0);
        chk("rst_stall", 32'(stall_cnt_o), 32'h0);
    endtask

    initial begin
        reset_n        = 1'b1;
        fifo_empty_i   = 1'b1;
        fifo_data_i    = '0;
        out_ready      = 1'b0;
        credit_flush_i = 1'b0;
        src_word       = 16'h1000;
        model_clear();

        // Reset with data available: no read allowed while held.
        #2 reset_n = 1'b0;
        fifo_empty_i = 1'b0;
        fifo_data_i  = src_word;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;

        // Streaming at full rate: two packets, two credit returns.
        repeat (40) step(1'b0, 1'b1, 1'b0);
        // Backpressure fills the buffer, then drain.
        repeat (6) step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0);
        // Partial credit flushes.
        step(1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        // Flush exactly on the threshold pop.
        for (int i = 0; i < 40; i++)
            step(1'b0, 1'b1, (mdl_ccnt == CREDIT_WORDS - 1) && (mdl_buf.size() != 0));

        // Mid-packet reset with a full buffer.
        repeat (5) step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        fifo_empty_i = 1'b0;
        #1 check_reset_outputs();
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);

        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("credit_sum", 32'(credit_sum), 32'(popped));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
